button_conditioner: RTL

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 74 +++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: polarity fix, 2-flop synchroniser,
// counted debounce and registered rise/fall pulses per channel.
module button_conditioner #(
  parameter int DB_CYCLES      = 16,
  parameter int BTN_ACTIVE_LOW = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic sample_tick,
  input  logic down_raw,
  input  logic in_raw,
  output logic down_clean,
  output logic down_rise,
  output logic down_fall,
  output logic in_clean,
  output logic in_rise,
  output logic in_fall
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic POL = (BTN_ACTIVE_LOW != 0);

  // Channel 0 is "down", channel 1 is "in"; both share identical logic.
  logic [1:0]       pin;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       stable;
  logic [1:0]       rise;
  logic [1:0]       fall;
  logic [CNT_W-1:0] count [2];

  assign pin = {in_raw, down_raw} ^ {2{POL}};

  // The counter only advances on ticks while the synchronised level disagrees
  // with the accepted level; agreement at any edge discards partial progress.
  always_ff @(posedge clock) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (!reset) begin
        s1[ch]     <= 1'b0;
        s2[ch]     <= 1'b0;
        stable[ch] <= 1'b0;
        rise[ch]   <= 1'b0;
        fall[ch]   <= 1'b0;
        count[ch]  <= '0;
      end else begin
        s1[ch]   <= pin[ch];
        s2[ch]   <= s1[ch];
        rise[ch] <= 1'b0;
        fall[ch] <= 1'b0;
        if (s2[ch] == stable[ch]) begin
          count[ch] <= '0;
        end else if (sample_tick) begin
          if (count[ch] == CNT_MAX) begin
            stable[ch] <= s2[ch];
            count[ch]  <= '0;
            rise[ch]   <= s2[ch];
            fall[ch]   <= ~s2[ch];
          end else begin
            count[ch] <= count[ch] + CNT_W'(1);
          end
        end
      end
    end
  end

  assign down_clean = stable[0];
  assign down_rise  = rise[0];
  assign down_fall  = fall[0];
  assign in_clean   = stable[1];
  assign in_rise    = rise[1];
  assign in_fall    = fall[1];

endmodule
